// File: rtl/hwag_ssram_arbiter.sv
// hwag SSRAM configuration-bus owner: loads the default register image after
// reset, then serves single transactions from host (m0) and monitor (m1) round-robin.
module hwag_ssram_arbiter #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter int                NUM_REGS = 64,
  parameter logic [DATA_W-1:0] INIT_R0  = 16'd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              err,
  output logic              init_done,
  output logic              ssram_we,
  output logic              ssram_re,
  output logic [ADDR_W-1:0] ssram_addr,
  output logic [DATA_W-1:0] ssram_dout,
  output logic              ssram_oe,
  input  logic [DATA_W-1:0] ssram_din
);

  localparam int               IDX_W      = $clog2(NUM_REGS + 1);
  localparam int               AW1        = ADDR_W + 1;
  localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [AW1-1:0]   NUM_REGS_A = AW1'(NUM_REGS);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                rr_ptr_q, rr_ptr_d;   // requester that wins the next contention (0=m0)
  logic                gnt_q, gnt_d;
  logic                txn_we_q, txn_we_d;
  logic                oor_q, oor_d;
  logic                ssram_we_q, ssram_we_d;
  logic                ssram_re_q, ssram_re_d;
  logic [ADDR_W-1:0]   ssram_addr_q, ssram_addr_d;
  logic [DATA_W-1:0]   ssram_dout_q, ssram_dout_d;
  logic                init_done_q, init_done_d;
  logic                m0_ack_q, m0_ack_d;
  logic                m1_ack_q, m1_ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;

  logic                sel_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic                sel_oor_s;
  logic [DATA_W-1:0]   rd_val_s;

  // Pick the requester to grant and mux its transaction fields
  always_comb begin
    if (m0_req && m1_req) begin
      sel_s = rr_ptr_q;
    end else if (m1_req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
    if (sel_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    sel_oor_s = ({1'b0, sel_addr_s} >= NUM_REGS_A);
  end

  // Read data is live from ssram_din during DONE and held in the _q flops otherwise,
  // because the SSRAM only presents data in the cycle the ack is due
  always_comb begin
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    if (oor_q) begin
      rd_val_s = {DATA_W{1'b0}};
    end else begin
      rd_val_s = ssram_din;
    end
    if ((state_q == S_DONE) && !txn_we_q) begin
      if (gnt_q) begin
        m1_rdata_d = rd_val_s;
      end else begin
        m0_rdata_d = rd_val_s;
      end
    end else begin
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
    end
  end

  // Next-state and next-output logic; strobes/acks are registered for the state being entered
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    txn_we_d     = txn_we_q;
    oor_d        = oor_q;
    ssram_we_d   = 1'b0;
    ssram_re_d   = 1'b0;
    ssram_addr_d = ssram_addr_q;
    ssram_dout_d = ssram_dout_q;
    init_done_d  = init_done_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      S_INIT: begin
        if (idx_q == IDX_END) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          ssram_we_d   = 1'b1;
          ssram_addr_d = ADDR_W'(idx_q);
          ssram_dout_d = (idx_q == {IDX_W{1'b0}}) ? INIT_R0 : {DATA_W{1'b0}};
          idx_d        = idx_q + IDX_ONE;
        end
      end
      S_IDLE: begin
        if (m0_req || m1_req) begin
          state_d      = S_ACCESS;
          gnt_d        = sel_s;
          rr_ptr_d     = ~sel_s;
          txn_we_d     = sel_we_s;
          oor_d        = sel_oor_s;
          ssram_addr_d = sel_addr_s;
          if (sel_oor_s) begin
            ssram_dout_d = ssram_dout_q;
          end else if (sel_we_s) begin
            ssram_we_d   = 1'b1;
            ssram_dout_d = sel_wdata_s;
          end else begin
            ssram_re_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        err_d   = oor_q;
        if (gnt_q) begin
          m1_ack_d = 1'b1;
        end else begin
          m0_ack_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_INIT;
      idx_q        <= {IDX_W{1'b0}};
      rr_ptr_q     <= 1'b0;
      gnt_q        <= 1'b0;
      txn_we_q     <= 1'b0;
      oor_q        <= 1'b0;
      ssram_we_q   <= 1'b0;
      ssram_re_q   <= 1'b0;
      ssram_addr_q <= {ADDR_W{1'b0}};
      ssram_dout_q <= {DATA_W{1'b0}};
      init_done_q  <= 1'b0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      err_q        <= 1'b0;
      m0_rdata_q   <= {DATA_W{1'b0}};
      m1_rdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      txn_we_q     <= txn_we_d;
      oor_q        <= oor_d;
      ssram_we_q   <= ssram_we_d;
      ssram_re_q   <= ssram_re_d;
      ssram_addr_q <= ssram_addr_d;
      ssram_dout_q <= ssram_dout_d;
      init_done_q  <= init_done_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      err_q        <= err_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
    end
  end

  assign ssram_we   = ssram_we_q;
  assign ssram_oe   = ssram_we_q;
  assign ssram_re   = ssram_re_q;
  assign ssram_addr = ssram_addr_q;
  assign ssram_dout = ssram_dout_q;
  assign init_done  = init_done_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign err        = err_q;
  assign m0_rdata   = m0_rdata_d;
  assign m1_rdata   = m1_rdata_d;

endmodule

// File: tb/tb_hwag_ssram_arbiter.sv
// Bench for hwag_ssram_arbiter: directed init/access/reset scenarios plus random
// two-requester traffic checked against a transaction-level register model.
module tb_hwag_ssram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic        err, init_done;
  logic        ssram_we, ssram_re, ssram_oe;
  logic [7:0]  ssram_addr;
  logic [15:0] ssram_dout, ssram_din;

  hwag_ssram_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .err(err), .init_done(init_done),
    .ssram_we(ssram_we), .ssram_re(ssram_re), .ssram_addr(ssram_addr),
    .ssram_dout(ssram_dout), .ssram_oe(ssram_oe), .ssram_din(ssram_din)
  );

  always #5 clk = ~clk;

  // SSRAM device: registered read, junk on the bus when not reading
  logic [15:0] sram [64];
  always @(posedge clk) begin
    if (ssram_we && ssram_addr < 8'd64) sram[ssram_addr[5:0]] <= ssram_dout;
    if (ssram_re && ssram_addr < 8'd64) ssram_din <= sram[ssram_addr[5:0]];
    else ssram_din <= 16'($urandom);
  end

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [15:0] ref_mem [64];
  bit          pend [2];
  int          start [2];
  int          cool [2];
  bit          t_we [2];
  logic [7:0]  t_addr [2];
  logic [15:0] t_wd [2];
  int          pref;
  int          ack_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive();
    m0_req = pend[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_wdata = t_wd[0];
    m1_req = pend[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_wdata = t_wd[1];
  endtask

  task automatic issue(input int m, input bit we, input logic [7:0] a, input logic [15:0] d);
    pend[m] = 1'b1; start[m] = cyc; t_we[m] = we; t_addr[m] = a; t_wd[m] = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = (i == 0) ? 16'd3 : 16'd0;
    pend[0] = 1'b0; pend[1] = 1'b0; pref = 0;
  endtask

  // Cycle by cycle after release: 64 default writes, then init_done with strobes low
  task automatic check_init();
    for (int k = 0; k < 64; k++) begin
      tick();
      check("init_write", {ssram_we, ssram_oe, ssram_re, init_done, m0_ack, m1_ack, ssram_addr, ssram_dout},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'(k), (k == 0) ? 16'd3 : 16'd0});
    end
    tick();
    check("init_done", {ssram_we, ssram_oe, ssram_re, init_done, m0_ack, m1_ack}, 6'b000100);
  endtask

  // Uncontended transaction issued in an IDLE cycle: strobe at +1, ack at +2
  task automatic dtxn(input int m, input bit we, input logic [7:0] a, input logic [15:0] d);
    bit in_r;
    in_r = (a < 8'd64);
    issue(m, we, a, d); drive();
    tick();
    check("acc_strobes", {ssram_we, ssram_oe, ssram_re, m0_ack, m1_ack},
          {we & in_r, we & in_r, !we & in_r, 1'b0, 1'b0});
    check("acc_addr", ssram_addr, a);
    if (we && in_r) check("acc_dout", ssram_dout, d);
    tick();
    check("dack", {m1_ack, m0_ack}, (m == 1) ? 2'b10 : 2'b01);
    check("derr", err, !in_r);
    if (!we) check("drdata", (m == 1) ? m1_rdata : m0_rdata, in_r ? ref_mem[a[5:0]] : 16'd0);
    else if (in_r) ref_mem[a[5:0]] = d;
    pend[m] = 1'b0; pref = 1 - m; drive();
    tick();
    tick();
  endtask

  // One cycle of the transaction-level model: validate every ack against the rules
  task automatic step();
    int g, o, lat;
    bit oor;
    tick();
    check("ack_overlap", m0_ack & m1_ack, 1'b0);
    check("oe_eq_we", ssram_oe, ssram_we);
    check("strobe_range", (ssram_we | ssram_re) & (ssram_addr >= 8'd64), 1'b0);
    if (!m0_ack && !m1_ack) check("err_idle", err, 1'b0);
    for (int m = 0; m < 2; m++) begin
      if ((m == 1) ? m1_ack : m0_ack) begin
        g = cyc - 2;
        o = 1 - m;
        check("ack_pending", pend[m], 1'b1);
        if (pend[o] && start[o] <= g) check("rr_winner", m, pref);
        pref = o;
        lat = cyc - start[m];
        check("latency", (lat >= 2) && (lat <= 5), 1'b1);
        oor = (t_addr[m] >= 8'd64);
        check("err", err, oor);
        if (!t_we[m]) check("rdata", (m == 1) ? m1_rdata : m0_rdata, oor ? 16'd0 : ref_mem[t_addr[m][5:0]]);
        else if (!oor) ref_mem[t_addr[m][5:0]] = t_wd[m];
        pend[m] = 1'b0;
        cool[m] = $urandom_range(2, 4);
        ack_log.push_back(m);
      end
    end
    drive();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    rst = 1'b0;
    t_we[0] = 1'b0; t_we[1] = 1'b0; t_addr[0] = 8'd0; t_addr[1] = 8'd0;
    t_wd[0] = 16'd0; t_wd[1] = 16'd0; cool[0] = 0; cool[1] = 0;
    model_reset();
    drive();
    repeat (3) tick();
    check("reset_outs", {ssram_we, ssram_re, ssram_oe, ssram_addr, ssram_dout, m0_ack, m1_ack,
                         err, init_done, m0_rdata, m1_rdata}, 64'd0);

    // Request pending through INIT; must be granted in the first IDLE cycle
    issue(0, 1'b1, 8'd5, 16'h1234); drive();
    rst = 1'b1;
    check_init();
    tick();
    check("first_grant_we", {ssram_we, ssram_re, ssram_addr, ssram_dout, m0_ack}, {1'b1, 1'b0, 8'd5, 16'h1234, 1'b0});
    tick();
    check("first_ack", {m0_ack, m1_ack, err}, 3'b100);
    ref_mem[5] = 16'h1234; pend[0] = 1'b0; pref = 1; drive();
    tick(); tick();

    dtxn(0, 1'b0, 8'd5, 16'd0);
    dtxn(1, 1'b0, 8'd5, 16'd0);
    dtxn(0, 1'b1, 8'd63, 16'hA5C3);
    dtxn(1, 1'b0, 8'd63, 16'd0);
    dtxn(1, 1'b0, 8'd70, 16'd0);
    dtxn(0, 1'b1, 8'd64, 16'hFFFF);
    dtxn(1, 1'b0, 8'd0, 16'd0);

    // Simultaneous requests, two rounds: expect m0,m1,m0,m1
    ack_log.delete();
    for (int r = 0; r < 2; r++) begin
      issue(0, 1'($urandom), 8'($urandom_range(0, 79)), 16'($urandom));
      issue(1, 1'($urandom), 8'($urandom_range(0, 79)), 16'($urandom));
      drive();
      n = 0;
      while ((pend[0] || pend[1]) && n < 20) begin step(); n++; end
      check("cont_complete", {pend[0], pend[1]}, 2'b00);
      step(); step();
    end
    check("cont_count", ack_log.size(), 4);
    for (int i = 0; i < ack_log.size() && i < 4; i++) check("cont_order", ack_log[i], i % 2);

    // Reset while a write is in ACCESS: dropped, outputs cleared, INIT restarts
    issue(0, 1'b1, 8'd10, 16'hBEEF); drive();
    tick();
    check("pre_reset_access", {ssram_we, ssram_addr}, {1'b1, 8'd10});
    rst = 1'b0;
    tick();
    check("midreset_outs", {ssram_we, ssram_re, ssram_oe, ssram_addr, ssram_dout, m0_ack, m1_ack,
                            err, init_done, m0_rdata, m1_rdata}, 64'd0);
    pend[0] = 1'b0; drive();
    tick();
    check("midreset_noack", {m0_ack, m1_ack, err, init_done}, 4'b0000);
    model_reset();
    rst = 1'b1;
    check_init();

    // Random traffic against the register model
    for (int i = 0; i < 1500; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) begin
          ok = ((cyc - start[m]) <= 8);
          check("wait_bound", ok, 1'b1);
          if (!ok) pend[m] = 1'b0;
        end else if (cool[m] > 0) begin
          cool[m]--;
        end else if ($urandom_range(0, 1) == 0) begin
          issue(m, 1'($urandom), 8'($urandom_range(0, 79)), 16'($urandom));
        end
      end
      drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
